// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: default operand width,
// operation codes and the control FSM state encoding.
package alu_pkg;

    localparam int LARGURA_PADRAO = 32;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        MULTIPLICA = 2'd1,
        DIVIDE     = 2'd2,
        FIM        = 2'd3
    } estado_t;

endpackage

// File: rtl/mul_div_iterativo.sv
// Iterative multiply/divide datapath: shift-add multiplication and restoring
// division on operand magnitudes, one bit per step, with the sign fix-up
// applied on the last step when HI/LO are written.
// The divider is built only when ALU_DIVISAO_EN is defined.
module mul_div_iterativo
    import alu_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
`ifdef ALU_DIVISAO_EN
    input  logic               ehDivisao,
    input  logic               carregaDivZero,
`endif
    input  logic               comSinal,
    input  logic               passo,
    input  logic [LARGURA-1:0] entrada1,
    input  logic [LARGURA-1:0] entrada2,
    output logic [LARGURA-1:0] hi,
    output logic [LARGURA-1:0] lo,
    output logic [LARGURA-1:0] loFinal,
    output logic               ultimoPasso
);

    localparam int CW = $clog2(LARGURA);

    function automatic logic [LARGURA-1:0] magnitude(input logic [LARGURA-1:0] v, input logic s);
        return (s && v[LARGURA-1]) ? -v : v;
    endfunction

    // acc holds the running product high half (mul) or partial remainder (div);
    // wLo holds the multiplier being shifted out or the quotient being shifted in.
    logic [LARGURA-1:0]   acc;
    logic [LARGURA-1:0]   wLo;
    logic [LARGURA-1:0]   operando;
    logic                 negaResultado;
    logic [CW-1:0]        contador;

    logic [LARGURA:0]     soma;
    logic [LARGURA-1:0]   hiProx;
    logic [LARGURA-1:0]   loProx;
    logic [LARGURA-1:0]   hiFinal;
    logic [2*LARGURA-1:0] produto;

`ifdef ALU_DIVISAO_EN
    logic                 modoDiv;
    logic                 negaResto;
    logic [LARGURA:0]     deslocado;
    logic [LARGURA:0]     tentativa;
    logic [LARGURA-1:0]   quociente;
    logic [LARGURA-1:0]   resto;
`endif

    assign ultimoPasso = (contador == CW'(LARGURA - 1));

    // One iteration of the selected algorithm plus the signed result it would give if final.
    always_comb begin
        soma    = {1'b0, acc} + (wLo[0] ? {1'b0, operando} : '0);
        hiProx  = soma[LARGURA:1];
        loProx  = {soma[0], wLo[LARGURA-1:1]};
        produto = {hiProx, loProx};
        if (negaResultado) begin
            produto = -produto;
        end
        hiFinal = produto[2*LARGURA-1:LARGURA];
        loFinal = produto[LARGURA-1:0];
`ifdef ALU_DIVISAO_EN
        // Restoring step: remainder is always below the divisor, so one extra bit suffices.
        deslocado = {acc, wLo[LARGURA-1]};
        tentativa = deslocado - {1'b0, operando};
        quociente = {wLo[LARGURA-2:0], ~tentativa[LARGURA]};
        resto     = tentativa[LARGURA] ? deslocado[LARGURA-1:0] : tentativa[LARGURA-1:0];
        if (modoDiv) begin
            hiProx  = resto;
            loProx  = quociente;
            hiFinal = negaResto ? -resto : resto;
            loFinal = negaResultado ? -quociente : quociente;
        end
`endif
    end

    // Operand load on accept, iteration while stepping, HI/LO written on the last step.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc           <= '0;
            wLo           <= '0;
            operando      <= '0;
            negaResultado <= 1'b0;
            contador      <= '0;
            hi            <= '0;
            lo            <= '0;
`ifdef ALU_DIVISAO_EN
            modoDiv       <= 1'b0;
            negaResto     <= 1'b0;
`endif
        end else if (iniciar) begin
            acc           <= '0;
            wLo           <= magnitude(entrada1, comSinal);
            operando      <= magnitude(entrada2, comSinal);
            negaResultado <= comSinal && (entrada1[LARGURA-1] ^ entrada2[LARGURA-1]);
            contador      <= '0;
`ifdef ALU_DIVISAO_EN
            modoDiv       <= ehDivisao;
            negaResto     <= comSinal && entrada1[LARGURA-1];
`endif
        end else if (passo) begin
            acc      <= hiProx;
            wLo      <= loProx;
            contador <= contador + 1'b1;
            if (ultimoPasso) begin
                hi       <= hiFinal;
                lo       <= loFinal;
                contador <= '0;
            end
`ifdef ALU_DIVISAO_EN
        end else if (carregaDivZero) begin
            hi <= entrada1;
            lo <= '1;
`endif
        end
    end

endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU top: control FSM, single-cycle operations and the
// registered result/flag outputs. Optional divider: ALU_DIVISAO_EN.
//
// Handshake: a request is accepted on a rising edge where valido && pronto;
// operands and code are captured only then. valido while pronto is low is
// dropped, not queued. valido_saida is a one-cycle pulse marking saida, zero
// and overflow as new; those outputs hold until the next completion.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               valido,
    output logic               pronto,
    input  logic [LARGURA-1:0] entrada1,
    input  logic [LARGURA-1:0] entrada2,
    input  logic [3:0]         unidadeControle,
    output logic [LARGURA-1:0] saida,
    output logic               valido_saida,
    output logic               zero,
    output logic               overflow,
    output estado_t            estado
);

    estado_t            proxEstado;
    logic               aceita;
    logic               ehMul;
    logic               comSinal;
    logic               iniciar;
    logic               passo;
    logic               ultimoPasso;
    logic [LARGURA-1:0] hi;
    logic [LARGURA-1:0] lo;
    logic [LARGURA-1:0] loFinal;
    logic [LARGURA-1:0] soma;
    logic [LARGURA-1:0] diferenca;
    logic [LARGURA-1:0] resultado;
    logic               ovfResultado;
`ifdef ALU_DIVISAO_EN
    logic               ehDiv;
    logic               divZero;
`endif

    // Decode which accepted operations start the iterative datapath.
    always_comb begin
        aceita = valido && pronto;
        ehMul  = (unidadeControle == OP_MULT) || (unidadeControle == OP_MULTU);
`ifdef ALU_DIVISAO_EN
        ehDiv    = (unidadeControle == OP_DIV) || (unidadeControle == OP_DIVU);
        divZero  = ehDiv && (entrada2 == '0);
        comSinal = (unidadeControle == OP_MULT) || (unidadeControle == OP_DIV);
        iniciar  = aceita && (ehMul || (ehDiv && !divZero));
`else
        comSinal = (unidadeControle == OP_MULT);
        iniciar  = aceita && ehMul;
`endif
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= proxEstado;
        end
    end

    // Next state and FSM-derived controls.
    always_comb begin
        proxEstado = estado;
        pronto     = (estado == OCIOSO);
        passo      = (estado == MULTIPLICA) || (estado == DIVIDE);
        case (estado)
            OCIOSO: begin
                if (aceita && ehMul) begin
                    proxEstado = MULTIPLICA;
`ifdef ALU_DIVISAO_EN
                end else if (aceita && ehDiv && !divZero) begin
                    proxEstado = DIVIDE;
`endif
                end
            end
            MULTIPLICA, DIVIDE: begin
                if (ultimoPasso) begin
                    proxEstado = FIM;
                end
            end
            FIM: begin
                proxEstado = OCIOSO;
            end
        endcase
    end

    // Single-cycle results; division by zero reports the all-ones quotient.
    always_comb begin
        soma         = entrada1 + entrada2;
        diferenca    = entrada1 - entrada2;
        resultado    = '0;
        ovfResultado = 1'b0;
        case (unidadeControle)
            OP_AND: resultado = entrada1 & entrada2;
            OP_OR:  resultado = entrada1 | entrada2;
            OP_ADD: begin
                resultado    = soma;
                ovfResultado = (entrada1[LARGURA-1] == entrada2[LARGURA-1]) &&
                               (soma[LARGURA-1] != entrada1[LARGURA-1]);
            end
            OP_SUB: begin
                resultado    = diferenca;
                ovfResultado = (entrada1[LARGURA-1] != entrada2[LARGURA-1]) &&
                               (diferenca[LARGURA-1] != entrada1[LARGURA-1]);
            end
            OP_SLT:  resultado = {{(LARGURA-1){1'b0}}, ($signed(entrada1) < $signed(entrada2))};
            OP_NOR:  resultado = ~(entrada1 | entrada2);
            OP_MFHI: resultado = hi;
            OP_MFLO: resultado = lo;
`ifdef ALU_DIVISAO_EN
            OP_DIV, OP_DIVU: resultado = '1;
`endif
            default: resultado = '0;
        endcase
    end

    // Output registers: load on the last iterative step or on a single-cycle accept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            saida        <= '0;
            zero         <= 1'b1;
            overflow     <= 1'b0;
            valido_saida <= 1'b0;
        end else begin
            valido_saida <= 1'b0;
            if (passo && ultimoPasso) begin
                saida        <= loFinal;
                zero         <= (loFinal == '0);
                overflow     <= 1'b0;
                valido_saida <= 1'b1;
            end else if (aceita && !iniciar) begin
                saida        <= resultado;
                zero         <= (resultado == '0);
                overflow     <= ovfResultado;
                valido_saida <= 1'b1;
            end
        end
    end

    mul_div_iterativo #(
        .LARGURA(LARGURA)
    ) u_mul_div (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
`ifdef ALU_DIVISAO_EN
        .ehDivisao     (ehDiv),
        .carregaDivZero(aceita && divZero),
`endif
        .comSinal      (comSinal),
        .passo         (passo),
        .entrada1      (entrada1),
        .entrada2      (entrada2),
        .hi            (hi),
        .lo            (lo),
        .loFinal       (loFinal),
        .ultimoPasso   (ultimoPasso)
    );

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo (LARGURA=32): table of directed
// vectors plus hand-written back-to-back, busy and reset-abort sequences.
module tb_alu_multiciclo;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clock;
    logic         reset;
    logic         valido;
    logic         pronto;
    logic [W-1:0] entrada1;
    logic [W-1:0] entrada2;
    logic [3:0]   unidadeControle;
    logic [W-1:0] saida;
    logic         valido_saida;
    logic         zero;
    logic         overflow;
    estado_t      estado;

    alu_multiciclo #(.LARGURA(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .valido         (valido),
        .pronto         (pronto),
        .entrada1       (entrada1),
        .entrada2       (entrada2),
        .unidadeControle(unidadeControle),
        .saida          (saida),
        .valido_saida   (valido_saida),
        .zero           (zero),
        .overflow       (overflow),
        .estado         (estado)
    );

    // Clock and watchdog.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Scoreboard.
    int           nCompared = 0;
    int           nFailed   = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        string        nome;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expSaida;
        logic         expZero;
        logic         expOvf;
        int           expLat;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input string nome, input logic [3:0] op,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] s, input logic z,
                                   input logic o, input int lat);
        vec_t v;
        v.nome = nome; v.op = op; v.a = a; v.b = b;
        v.expSaida = s; v.expZero = z; v.expOvf = o; v.expLat = lat;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nome, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nFailed++;
            $display("FAIL %s: got %0h expected %0h", nome, got, exp);
        end
    endtask

    // Drivers: all tasks start and end just after a falling edge.
    task automatic runVec(input vec_t v);
        int lat;
        logic [W-1:0] esperado;
        lat = 0;
        exp_q.push_back(v.expSaida);
        valido          = 1'b1;
        unidadeControle = v.op;
        entrada1        = v.a;
        entrada2        = v.b;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock);
            if (k == 1) begin
                valido          = 1'b0;
                entrada1        = $urandom;
                entrada2        = $urandom;
                unidadeControle = 4'($urandom_range(0, 15));
                if (v.expLat > 1) check({v.nome, ".pronto_busy"}, 64'(pronto), 64'd0);
            end
            if (valido_saida) begin
                lat = k;
                break;
            end
        end
        esperado = exp_q.pop_front();
        check({v.nome, ".latency"}, 64'(lat), 64'(v.expLat));
        check({v.nome, ".saida"}, 64'(saida), 64'(esperado));
        check({v.nome, ".zero"}, 64'(zero), 64'(v.expZero));
        check({v.nome, ".overflow"}, 64'(overflow), 64'(v.expOvf));
        @(negedge clock);
        check({v.nome, ".pulse_end"}, 64'(valido_saida), 64'd0);
        check({v.nome, ".hold"}, 64'(saida), 64'(esperado));
    endtask

    task automatic runOp(input string nome, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] s, input logic z,
                         input logic o, input int lat);
        vec_t v;
        v.nome = nome; v.op = op; v.a = a; v.b = b;
        v.expSaida = s; v.expZero = z; v.expOvf = o; v.expLat = lat;
        runVec(v);
    endtask

    task automatic countPulses(input int ciclos, output int n);
        n = 0;
        for (int k = 0; k < ciclos; k++) begin
            @(negedge clock);
            if (valido_saida) n++;
        end
    endtask

    initial begin
        int lat;
        int pulsos;

        addVec("and",        OP_AND,   32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 1);
        addVec("or",         OP_OR,    32'h12340000, 32'h00005678, 32'h12345678, 0, 0, 1);
        addVec("add_ovf",    OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 1);
        addVec("invalid",    4'b0011,  32'h12345678, 32'h00000009, 32'h00000000, 1, 0, 1);
        addVec("add_wrap",   OP_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1);
        addVec("add_negovf", OP_ADD,   32'h80000000, 32'h80000000, 32'h00000000, 1, 1, 1);
        addVec("sub_ovf",    OP_SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 1);
        addVec("sub_neg",    OP_SUB,   32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 0, 1);
        addVec("slt_neg",    OP_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 1);
        addVec("slt_pos",    OP_SLT,   32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1, 0, 1);
        addVec("nor",        OP_NOR,   32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F, 0, 0, 1);
        addVec("mult",       OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 0, 0, 33);
        addVec("mfhi_mult",  OP_MFHI,  32'h0,        32'h0,        32'hFFFFFFFF, 0, 0, 1);
        addVec("mflo_mult",  OP_MFLO,  32'h0,        32'h0,        32'hFFFFFFFA, 0, 0, 1);
        addVec("multu",      OP_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 0, 0, 33);
        addVec("mfhi_multu", OP_MFHI,  32'h0,        32'h0,        32'h00000002, 0, 0, 1);
`ifdef ALU_DIVISAO_EN
        addVec("div",        OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 0, 0, 33);
        addVec("mfhi_div",   OP_MFHI,  32'h0,        32'h0,        32'hFFFFFFFF, 0, 0, 1);
        addVec("divu_zero",  OP_DIVU,  32'h00000007, 32'h00000000, 32'hFFFFFFFF, 0, 0, 1);
        addVec("mfhi_divz",  OP_MFHI,  32'h0,        32'h0,        32'h00000007, 0, 0, 1);
        addVec("div_wrap",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 33);
        addVec("mfhi_dwrap", OP_MFHI,  32'h0,        32'h0,        32'h00000000, 1, 0, 1);
        addVec("divu",       OP_DIVU,  32'h00000064, 32'h00000007, 32'h0000000E, 0, 0, 33);
        addVec("mfhi_divu",  OP_MFHI,  32'h0,        32'h0,        32'h00000002, 0, 0, 1);
`else
        addVec("div_off",    OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'h00000000, 1, 0, 1);
        addVec("divu_off",   OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000000, 1, 0, 1);
        addVec("mfhi_off",   OP_MFHI,  32'h0,        32'h0,        32'h00000002, 0, 0, 1);
        addVec("mflo_off",   OP_MFLO,  32'h0,        32'h0,        32'hFFFFFFFA, 0, 0, 1);
`endif
        addVec("mult_wrap",  OP_MULT,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 33);
        addVec("mfhi_mwrap", OP_MFHI,  32'h0,        32'h0,        32'h00000000, 1, 0, 1);
        addVec("mult_zero",  OP_MULT,  32'h00000000, 32'h00000005, 32'h00000000, 1, 0, 33);
        addVec("add_ovf2",   OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 1);
        addVec("mult_pos",   OP_MULT,  32'h00000007, 32'h00000006, 32'h0000002A, 0, 0, 33);

        // Reset state.
        reset = 1'b0; valido = 1'b0;
        entrada1 = '0; entrada2 = '0; unidadeControle = '0;
        repeat (2) @(negedge clock);
        check("reset.pronto", 64'(pronto), 64'd1);
        check("reset.saida", 64'(saida), 64'd0);
        check("reset.zero", 64'(zero), 64'd1);
        check("reset.overflow", 64'(overflow), 64'd0);
        check("reset.valido_saida", 64'(valido_saida), 64'd0);
        check("reset.estado", 64'(estado), 64'(OCIOSO));
        reset = 1'b1;

        // Table-driven vectors; the first one is accepted on the first edge after release.
        foreach (vecs[i]) runVec(vecs[i]);

        // Back-to-back SUB then SLT on consecutive cycles.
        valido = 1'b1; unidadeControle = OP_SUB; entrada1 = 32'd5; entrada2 = 32'd5;
        @(negedge clock);
        check("b2b.sub_valid", 64'(valido_saida), 64'd1);
        check("b2b.sub_zero", 64'(zero), 64'd1);
        check("b2b.pronto", 64'(pronto), 64'd1);
        unidadeControle = OP_SLT; entrada1 = 32'hFFFFFFFF; entrada2 = 32'd1;
        @(negedge clock);
        valido = 1'b0;
        check("b2b.slt_valid", 64'(valido_saida), 64'd1);
        check("b2b.slt_saida", 64'(saida), 64'd1);
        check("b2b.slt_zero", 64'(zero), 64'd0);
        @(negedge clock);
        check("b2b.pulse_end", 64'(valido_saida), 64'd0);

        // valido held high through a MULT while inputs change: nothing extra executes.
        valido = 1'b1; unidadeControle = OP_MULT; entrada1 = 32'd2; entrada2 = 32'd3;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock);
            if (k == 1) begin
                unidadeControle = OP_ADD; entrada1 = 32'd10; entrada2 = 32'd10;
            end
            if (valido_saida) begin
                lat = k;
                valido = 1'b0;
                break;
            end
        end
        valido = 1'b0;
        check("busy.latency", 64'(lat), 64'd33);
        check("busy.saida", 64'(saida), 64'd6);
        countPulses(5, pulsos);
        check("busy.extra_pulses", 64'(pulsos), 64'd1 - 64'd1);
        runOp("busy.mfhi", OP_MFHI, '0, '0, 32'd0, 1'b1, 1'b0, 1);
        runOp("busy.mflo", OP_MFLO, '0, '0, 32'd6, 1'b0, 1'b0, 1);

        // Reset 10 cycles into a MULT aborts it without a result pulse.
        runOp("abort.pre_add", OP_ADD, 32'h11, 32'h22, 32'h33, 1'b0, 1'b0, 1);
        valido = 1'b1; unidadeControle = OP_MULT; entrada1 = 32'hFFFFFFFE; entrada2 = 32'd3;
        repeat (10) @(negedge clock);
        check("abort.busy_pronto", 64'(pronto), 64'd0);
        check("abort.busy_hold", 64'(saida), 64'h33);
        check("abort.busy_valid", 64'(valido_saida), 64'd0);
        reset = 1'b0;
        valido = 1'b0;
        #1;
        check("abort.pronto", 64'(pronto), 64'd1);
        check("abort.saida", 64'(saida), 64'd0);
        check("abort.zero", 64'(zero), 64'd1);
        check("abort.estado", 64'(estado), 64'(OCIOSO));
        @(negedge clock);
        reset = 1'b1;
        countPulses(40, pulsos);
        check("abort.no_pulse", 64'(pulsos), 64'd0);
        runOp("abort.mfhi", OP_MFHI, '0, '0, 32'd0, 1'b1, 1'b0, 1);
        runOp("abort.mflo", OP_MFLO, '0, '0, 32'd0, 1'b1, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
